// File: rtl/insn_encoder.sv
// insn_encoder: packs instruction fields into 32-bit words, queues them in a 4-entry
// FIFO and streams them to instruction memory. Optional macro: INSN_ENC_CHECK_EN (opcode checking, err port).
module insn_encoder (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_shamt,
    input  logic [4:0]  in_aluop,
    input  logic [16:0] in_imm,
    input  logic [26:0] in_target,
    input  logic        addr_load,
    input  logic [11:0] addr_in,
    output logic        im_we,
    output logic [11:0] im_addr,
    output logic [31:0] im_data,
    input  logic        im_ack,
    output logic        busy,
    output logic [2:0]  count
`ifdef INSN_ENC_CHECK_EN
    ,
    output logic        err
`endif
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WR   = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_mem [4];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_count;
    logic [2:0]  w_count_next;
    logic [11:0] r_addr;
    logic [31:0] w_word;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;

    // NOTE: every signal written in an always_comb gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        w_word = {in_op, 27'd0};
        case (in_op)
            5'b00000:
                w_word = {in_op, in_rd, in_rs, in_rt, in_shamt, in_aluop, 2'b00};
            5'b00101, 5'b00111, 5'b01000, 5'b00010, 5'b00110:
                w_word = {in_op, in_rd, in_rs, in_imm};
            5'b00100:
                w_word = {in_op, in_rd, 22'd0};
            5'b00001, 5'b00011, 5'b10110, 5'b10101:
                w_word = {in_op, in_target};
            default:
                w_word = {in_op, 27'd0};
        endcase
    end

    assign w_accept = in_valid & in_ready;
    assign w_pop    = (r_state == ST_WR) & im_ack;

`ifdef INSN_ENC_CHECK_EN
    logic w_legal;
    logic r_err;

    assign w_legal = in_op inside {5'b00000, 5'b00101, 5'b00111, 5'b01000, 5'b00010,
                                   5'b00110, 5'b00100, 5'b00001, 5'b00011, 5'b10110,
                                   5'b10101};
    // Illegal opcodes complete the handshake but are dropped.
    assign w_push   = w_accept & w_legal;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept & ~w_legal;
        end
    end

    assign err = r_err;
`else
    assign w_push = w_accept;
`endif

    assign w_count_next = r_count + {2'b00, w_push} - {2'b00, w_pop};

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_count  <= 3'd0;
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_count_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
        end
    end

    // NOTE: the storage array is not reset; validity is tracked by the pointers and
    // count, and im_data is forced to zero whenever no write is in progress.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                // Entering WR on the accept edge gives the one-cycle minimum latency.
                if (r_count != 3'd0 || w_push) begin
                    w_next_state = ST_WR;
                end
            end
            ST_WR: begin
                if (w_pop && w_count_next == 3'd0) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_addr <= 12'd0;
        end else if (w_pop) begin
            r_addr <= r_addr + 12'd1;
        end else if (addr_load && r_state == ST_IDLE && r_count == 3'd0) begin
            r_addr <= addr_in;
        end
    end

    assign in_ready = (r_count != 3'd4);
    assign im_we    = (r_state == ST_WR);
    assign im_addr  = r_addr;
    assign im_data  = im_we ? r_mem[r_rd_ptr] : 32'd0;
    assign busy     = (r_count != 3'd0) || (r_state == ST_WR);
    assign count    = r_count;

endmodule
